// File: rtl/vga_native_arbiter.sv
// Round-robin arbiter sharing one single-port register file between the AXI-Lite
// write and read paths. Every memory-side and grant output is registered.
module vga_native_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD} state_t;

  state_t                r_state;
  logic                  r_last_rd;
  logic                  r_wr_gnt;
  logic                  r_rd_gnt;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_hold;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_wr_elig;
  logic w_rd_elig;
  logic w_pick_wr;
  logic w_pick_rd;
  logic w_conflict;

  always_comb begin
    w_wr_elig  = wr_req && (r_state != GNT_WR);
    w_rd_elig  = rd_req && (r_state != GNT_RD);
    w_pick_wr  = w_wr_elig && (!w_rd_elig || r_last_rd);
    w_pick_rd  = w_rd_elig && !w_pick_wr;
    // Both requesters pending at an arbitration edge, even while one of them is
    // still masked by its own grant cycle.
    w_conflict = wr_req && rd_req;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= IDLE;
      r_last_rd   <= 1'b1;
      r_wr_gnt    <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_hold   <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_pick_wr) begin
        r_state     <= GNT_WR;
        r_last_rd   <= 1'b0;
        r_mem_addr  <= wr_addr;
        r_mem_wdata <= wr_data;
      end else if (w_pick_rd) begin
        r_state     <= GNT_RD;
        r_last_rd   <= 1'b1;
        r_mem_addr  <= rd_addr;
        r_mem_wdata <= '0;
      end else begin
        r_state     <= IDLE;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
      end
      r_wr_gnt   <= w_pick_wr;
      r_rd_gnt   <= w_pick_rd;
      r_mem_en   <= w_pick_wr || w_pick_rd;
      r_mem_we   <= w_pick_wr;
      r_rd_valid <= (r_state == GNT_RD);
      if (r_rd_valid) begin
        r_rd_hold <= mem_rdata;
      end
      if (w_conflict && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Memory returns data the cycle after the read grant, so the valid cycle passes
  // it straight through and the holding register keeps it afterwards.
  assign rd_data      = r_rd_valid ? mem_rdata : r_rd_hold;
  assign rd_valid     = r_rd_valid;
  assign wr_gnt       = r_wr_gnt;
  assign rd_gnt       = r_rd_gnt;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_vga_native_arbiter.sv
// Directed bench for vga_native_arbiter with a behavioural single-port memory;
// a second instance with a 2-bit counter shares the stimulus.
module tb_vga_native_arbiter;

  logic        clk;
  logic        arst;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  logic        s_wr_gnt;
  logic        s_rd_gnt;
  logic [31:0] s_rd_data;
  logic        s_rd_valid;
  logic        s_mem_en;
  logic        s_mem_we;
  logic [7:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [1:0]  s_conflict_cnt;

  logic [31:0] mem [256];

  int n_pass;
  int n_total;

  vga_native_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .arst(arst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  vga_native_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .arst(arst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(s_wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(s_rd_gnt), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    arst = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    mem_rdata = '0;
    #2;
    do_reset();

    chk("reset_wr_gnt", wr_gnt, 0);
    chk("reset_rd_gnt", rd_gnt, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_cnt", conflict_cnt, 0);

    // Single write
    wr_req = 1'b1; wr_addr = 8'h04; wr_data = 32'hDEADBEEF;
    step();
    chk("wr_gnt", wr_gnt, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h04);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    wr_req = 1'b0;
    step();
    chk("wr_idle_gnt", wr_gnt, 0);
    chk("wr_idle_addr", mem_addr, 0);

    // Read-after-write, then a write to the same word right behind the read
    rd_req = 1'b1; rd_addr = 8'h04;
    step();
    chk("rd_gnt", rd_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h04);
    chk("rd_mem_wdata", mem_wdata, 0);
    chk("rd_early_valid", rd_valid, 0);
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 8'h04; wr_data = 32'h12345678;
    step();
    chk("raw_rd_valid", rd_valid, 1);
    chk("raw_rd_data", rd_data, 32'hDEADBEEF);
    chk("wr_after_rd_gnt", wr_gnt, 1);
    chk("wr_after_rd_wdata", mem_wdata, 32'h12345678);
    wr_req = 1'b0;
    step();
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_hold", rd_data, 32'hDEADBEEF);
    chk("seq_no_conflict", conflict_cnt, 0);
    rd_req = 1'b1; rd_addr = 8'h04;
    step();
    rd_req = 1'b0;
    step();
    chk("reread_valid", rd_valid, 1);
    chk("reread_data", rd_data, 32'h12345678);

    // Simultaneous after reset: write first
    do_reset();
    wr_req = 1'b1; wr_addr = 8'h08; wr_data = 32'hA5A5A5A5;
    rd_req = 1'b1; rd_addr = 8'h04;
    step();
    chk("tie_wr_first", wr_gnt, 1);
    chk("tie_rd_wait", rd_gnt, 0);
    chk("tie_cnt", conflict_cnt, 1);
    wr_req = 1'b0;
    step();
    chk("tie_rd_next", rd_gnt, 1);
    chk("tie_wr_done", wr_gnt, 0);
    chk("tie_rd_addr", mem_addr, 8'h04);
    rd_req = 1'b0;
    step();
    chk("tie_rd_valid", rd_valid, 1);
    chk("tie_rd_data", rd_data, 32'h12345678);
    chk("tie_cnt_final", conflict_cnt, 1);

    // Saturation with a 2-bit counter
    do_reset();
    wr_req = 1'b1; wr_addr = 8'h30; wr_data = 32'h0;
    rd_req = 1'b1; rd_addr = 8'h30;
    step(); step(); step();
    chk("sat_cnt3_wide", conflict_cnt, 3);
    chk("sat_cnt3_narrow", s_conflict_cnt, 3);
    step(); step();
    chk("sat_cnt5_wide", conflict_cnt, 5);
    chk("sat_cnt5_narrow", s_conflict_cnt, 3);
    wr_req = 1'b0; rd_req = 1'b0;
    step(); step();

    // Continuous requesting: strict alternation, 8 transactions each
    do_reset();
    wr_req = 1'b1; wr_addr = 8'h10; wr_data = 32'h100;
    rd_req = 1'b1; rd_addr = 8'h20;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("alt_wr_gnt_%0d", k), wr_gnt, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("alt_rd_gnt_%0d", k), rd_gnt, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 1) begin
        if (k == 15) wr_req = 1'b0;
        else begin
          wr_addr = wr_addr + 8'd1;
          wr_data = wr_data + 32'd1;
        end
      end else if (k == 16) begin
        rd_req = 1'b0;
      end
    end
    chk("alt_cnt_wide", conflict_cnt, 15);
    chk("alt_cnt_narrow", s_conflict_cnt, 3);
    step();
    chk("alt_last_rd_valid", rd_valid, 1);
    step();

    // Reset during a read grant
    rd_req = 1'b1; rd_addr = 8'h04;
    step();
    chk("rst_pre_rd_gnt", rd_gnt, 1);
    #2;
    arst = 1'b1;
    rd_req = 1'b0;
    #1;
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    step();
    chk("rst_hold_rd_valid", rd_valid, 0);
    arst = 1'b0;
    step();
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_gnts", {wr_gnt, rd_gnt}, 0);
    step();
    chk("post_rst_idle", mem_en, 0);
    wr_req = 1'b1; wr_addr = 8'h40; wr_data = 32'h55;
    rd_req = 1'b1; rd_addr = 8'h40;
    step();
    chk("post_rst_wr_first", wr_gnt, 1);
    chk("post_rst_cnt", conflict_cnt, 1);
    wr_req = 1'b0;
    step();
    chk("post_rst_rd_second", rd_gnt, 1);
    rd_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
